// File: rtl/spi_slave_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_sync
//   SPI slave front end (mode 0, MSB first, active-low cs) that runs entirely
//   on the system clock. sclk, cs and mosi are oversampled through
//   synchronizer chains. Edges are detected on clk, one WIDTH-bit word per
//   frame is deserialized into rx_data, and tx_data (latched at frame start)
//   is shifted out on miso.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   sclk       SPI clock from master (asynchronous to clk)
//   cs         SPI chip select, active-low (asynchronous to clk)
//   mosi       SPI data in (asynchronous to clk)
//   miso       SPI data out, tx_shift MSB while a frame is in progress
//   tx_data    word returned in the frame, sampled only at cs fall
//   rx_data    last complete received word, held until the next rx_valid
//   rx_valid   one-cycle pulse, rx_data was updated
//   frame_err  one-cycle pulse at frame end when the bit count != WIDTH
//   busy       high while a frame is in progress
// ---------------------------------------------------------------------------
module spi_slave_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, warm;
  logic                   sclk_d, cs_d, armed;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [WIDTH-1:0]       rx_shift, tx_shift, rx_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   overrun;

  // Synchronizers preset to an idle bus so reset release produces no edges.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      warm      <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      // A frame may only start after cs has really been seen high: the preset
      // ones draining out of the chain while the pin is low are not a cs fall.
      armed     <= armed | (warm[SYNC_STAGES-1] & cs_s);
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = armed & ~cs_s & cs_d;
  assign rx_next   = {rx_shift[WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (cs_fall) state_next = ACTIVE;
      ACTIVE: begin
        if (cs_rise)
          state_next = IDLE;
        else if (sclk_rise && bit_cnt == CNT_W'(WIDTH - 1))
          state_next = DONE;
      end
      DONE:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. cs_rise is tested first so a coincident sclk edge is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            bit_cnt  <= '0;
            overrun  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Short frame: report it and leave rx_data untouched.
            frame_err <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end
            end
            if (sclk_fall) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          if (cs_rise) begin
            frame_err <= overrun;
          end else if (sclk_rise) begin
            overrun <= 1'b1;
            bit_cnt <= CNT_W'(WIDTH + 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign miso = busy & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave_sync.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_sync
//   Directed bench for spi_slave_sync (WIDTH=16, SYNC_STAGES=2). The master
//   runs sclk at clk/8. A table of frames is applied in a loop, followed by
//   hand-written sequences for back-to-back feedback and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_spi_slave_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = '0;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err, busy;

  int checks   = 0;
  int failures = 0;

  spi_slave_sync #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counters only grow; tests compare deltas.
  int rxv_total  = 0;
  int ferr_total = 0;
  int both_total = 0;
  always @(negedge clk) begin
    if (rx_valid)              rxv_total  <= rxv_total + 1;
    if (frame_err)             ferr_total <= ferr_total + 1;
    if (rx_valid && frame_err) both_total <= both_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock nbits bits out of word (MSB first) with cs already low; the first
  // 16 miso bits seen just before each rise are collected into miso_word.
  // tx_data is inverted after bit 3 to show mid-frame changes are ignored.
  task automatic send_bits(input logic [15:0] word, input int nbits,
                           output logic [15:0] miso_word);
    logic [15:0] w;
    w = word;
    miso_word = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15 - i] : 1'b0;
      if (i == 3) tx_data = ~tx_data;
      wait_clk(4);
      if (i < 16) miso_word = {miso_word[14:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic frame(input logic [15:0] word, input logic [15:0] tx,
                       input int nbits, output logic [15:0] miso_word);
    tx_data = tx;
    cs = 1'b0;
    wait_clk(6);
    send_bits(word, nbits, miso_word);
    wait_clk(6);
    cs = 1'b1;
  endtask

  typedef struct {
    logic [15:0] mosi_word;
    logic [15:0] tx_word;
    int          nbits;
    logic [15:0] exp_miso;
    int          exp_rxv;
    int          exp_ferr;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] mw;
    int rxv0, ferr0;

    vecs[0] = '{16'h1234, 16'hEDCB, 16, 16'hEDCB, 1, 0, 16'h1234};
    vecs[1] = '{16'hABCD, 16'h8000,  7, 16'h0040, 0, 1, 16'h1234};
    vecs[2] = '{16'h5A5A, 16'hC3C3, 17, 16'hC3C3, 1, 1, 16'h5A5A};
    vecs[3] = '{16'h0000, 16'hFFFF,  0, 16'h0000, 0, 1, 16'h5A5A};
    vecs[4] = '{16'h0000, 16'hFFFF, 16, 16'hFFFF, 1, 0, 16'h0000};

    // Reset and idle.
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(20);
    check("reset_miso",      32'(miso),      32'(0));
    check("reset_rx_data",   32'(rx_data),   32'(0));
    check("reset_rx_valid",  32'(rx_valid),  32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_busy",      32'(busy),      32'(0));
    check("reset_pulses",    32'(rxv_total + ferr_total), 32'(0));

    // Table of frames.
    for (int v = 0; v < 5; v++) begin
      rxv0  = rxv_total;
      ferr0 = ferr_total;
      frame(vecs[v].mosi_word, vecs[v].tx_word, vecs[v].nbits, mw);
      wait_clk(4);
      check($sformatf("vec%0d_busy_low", v), 32'(busy), 32'(0));
      wait_clk(4);
      check($sformatf("vec%0d_miso", v),     32'(mw), 32'(vecs[v].exp_miso));
      check($sformatf("vec%0d_rx_valid", v), 32'(rxv_total - rxv0), 32'(vecs[v].exp_rxv));
      check($sformatf("vec%0d_frame_err", v), 32'(ferr_total - ferr0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_rx_data", v),  32'(rx_data), 32'(vecs[v].exp_rx));
    end

    // Back-to-back frames with the received word inverted and fed back.
    rxv0 = rxv_total;
    frame(16'hFFFF, 16'h1111, 16, mw);
    wait_clk(8);
    frame(16'h0001, ~rx_data, 16, mw);
    wait_clk(8);
    check("b2b_miso",     32'(mw),      32'(16'h0000));
    check("b2b_rx_data",  32'(rx_data), 32'(16'h0001));
    check("b2b_rx_valid", 32'(rxv_total - rxv0), 32'(2));

    // Reset mid-frame, released with cs still low.
    rxv0  = rxv_total;
    ferr0 = ferr_total;
    tx_data = 16'h0F0F;
    cs = 1'b0;
    wait_clk(6);
    send_bits(16'hAAAA, 8, mw);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("rst_mid_rx_data", 32'(rx_data), 32'(0));
    send_bits(16'hFFFF, 16, mw);
    wait_clk(6);
    check("rst_mid_busy",     32'(busy), 32'(0));
    check("rst_mid_miso",     32'(mw),   32'(0));
    cs = 1'b1;
    wait_clk(8);
    check("rst_mid_no_pulse", 32'(rxv_total - rxv0 + ferr_total - ferr0), 32'(0));
    frame(16'h00FF, 16'h3C3C, 16, mw);
    wait_clk(8);
    check("after_rst_rx_valid", 32'(rxv_total - rxv0), 32'(1));
    check("after_rst_rx_data",  32'(rx_data), 32'(16'h00FF));
    check("after_rst_miso",     32'(mw),      32'(16'h3C3C));

    check("never_both_pulses", 32'(both_total), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
